// File: rtl/par2ser_pkg.sv
// par2ser_pkg: constants and helpers shared by the serializer blocks.
//   DIR_MSB_FIRST / DIR_LSB_FIRST : values of the 'direct' bit-order input
//   clog2()                       : ceiling log2, never below 1
//   shift_state_t                 : busy/idle state of the shifter
package par2ser_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

  // Constant function; result is at least 1 so counters never collapse to 0 bits.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = 32'(i + 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/par2ser_hold.sv
// par2ser_hold: one-word valid/ready holding register in front of the shifter.
//   clock, reset : clock and synchronous active-high reset
//   enable       : clock enable; 0 freezes state and drops iready
//   direct       : bit order captured together with each accepted word
//   ivalid/idata : upstream word offer
//   load         : shifter is taking the held word this cycle
//   iready       : a word can be accepted this cycle
//   hold/hold_dir/hold_full : held word, its bit order, occupancy
module par2ser_hold
  import par2ser_pkg::*;
#(
  parameter int unsigned LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  input  logic [LENGTH-1:0] idata,
  input  logic              load,
  output logic              iready,
  output logic [LENGTH-1:0] hold,
  output logic              hold_dir,
  output logic              hold_full
);

  logic accept;

  // Space exists when empty, or when the current word leaves this very edge.
  assign iready = enable & ~reset & (~hold_full | load);
  assign accept = ivalid & iready;

  // Holding register; accept wins over load so the slot stays full on a swap.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold      <= '0;
      hold_dir  <= DIR_MSB_FIRST;
      hold_full <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        hold      <= idata;
        hold_dir  <= direct;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/par2ser.sv
// par2ser: parallel-to-serial converter feeding ser2par.
//   clock, reset : clock and synchronous active-high reset
//   enable       : clock enable; 0 freezes all state, iready and ovalid low
//   direct       : bit order for the offered word (0 MSB first, 1 LSB first)
//   ivalid/iready/idata : word input handshake
//   ovalid/odata : serial bit and its strobe
//   olast        : final bit of a word
module par2ser
  import par2ser_pkg::*;
#(
  parameter int unsigned LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  output logic              iready,
  input  logic [LENGTH-1:0] idata,
  output logic              ovalid,
  output logic              odata,
  output logic              olast
);

  localparam int unsigned CW = clog2(LENGTH);

  logic [LENGTH-1:0] hold;
  logic              hold_dir;
  logic              hold_full;
  logic              load;
  logic              last_bit;

  shift_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-1:0] sreg_q, sreg_d;
  logic              sdir_q, sdir_d;

  par2ser_hold #(
    .LENGTH (LENGTH)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .direct    (direct),
    .ivalid    (ivalid),
    .idata     (idata),
    .load      (load),
    .iready    (iready),
    .hold      (hold),
    .hold_dir  (hold_dir),
    .hold_full (hold_full)
  );

  assign last_bit = (cnt_q == CW'(LENGTH - 1));
  // Held word moves into the shifter when idle or on the last bit (gapless).
  assign load     = hold_full & ((state_q == ST_IDLE) | last_bit);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      sdir_q  <= DIR_MSB_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      sdir_q  <= sdir_d;
    end
  end

  // Next state and outputs; load takes priority over shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    sdir_d  = sdir_q;
    ovalid  = 1'b0;
    olast   = 1'b0;
    odata   = 1'b0;

    if (enable) begin
      if (load) begin
        state_d = ST_SHIFT;
        sreg_d  = hold;
        sdir_d  = hold_dir;
        cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
        if (last_bit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sreg_d = (sdir_q == DIR_LSB_FIRST) ? (sreg_q >> 1) : (sreg_q << 1);
        end
      end
    end

    // Outputs are forced low while reset is asserted.
    if (!reset) begin
      ovalid = enable & (state_q == ST_SHIFT);
      olast  = ovalid & last_bit;
      odata  = (sdir_q == DIR_LSB_FIRST) ? sreg_q[0] : sreg_q[LENGTH-1];
    end
  end

endmodule
